// File: rtl/conv_window_scheduler.sv
// conv_window_scheduler
//   Sequences a single convolution MAC over a feature map held in a
//   synchronous-read pixel RAM and a kernel held in a weight RAM. Windows
//   are visited in raster order (stride 1, valid padding). Each finished
//   window result is pushed into a 4-entry FIFO together with its output
//   index.
//
// Ports
//   clk, reset_n          clock (rising edge), asynchronous active-low reset
//   start                 one-cycle pulse, starts a layer pass when not busy
//   busy, done            pass in progress / one-cycle end-of-pass pulse
//   pix_rd                pixel + weight RAM read strobe
//   pix_addr, krn_addr    pixel address (r+i)*IMG_W+(c+j), weight address i*K+j
//   mac_enable, mac_clear MAC controls; mac_ht/mac_wt are the constant K
//   mac_out, mac_done     MAC saturated result and its done flag
//   res_valid, res_ready  FIFO head handshake
//   res_data, res_addr    FIFO head result and output index r*OW+c
//   seq_err               sticky, set when mac_done is low on a capture cycle
//   dbg_state             current FSM state (state_t encoding)
//
// Handshake: the FIFO head is transferred on every rising edge where
// res_valid and res_ready are both high. res_valid never depends on
// res_ready, and the head stays stable until it is transferred.
module conv_window_scheduler #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int K      = 3,
    parameter int ADDR_W = 10,
    parameter int RES_W  = 21
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pix_rd,
    output logic [ADDR_W-1:0] pix_addr,
    output logic [5:0]        krn_addr,
    output logic              mac_enable,
    output logic              mac_clear,
    output logic [8:0]        mac_ht,
    output logic [8:0]        mac_wt,
    input  logic [RES_W-1:0]  mac_out,
    input  logic              mac_done,
    output logic              res_valid,
    output logic [RES_W-1:0]  res_data,
    output logic [ADDR_W-1:0] res_addr,
    input  logic              res_ready,
    output logic              seq_err,
    output logic [2:0]        dbg_state
);

    localparam int OW = IMG_W - K + 1;
    localparam int OH = IMG_H - K + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_RUN   = 3'd2,
        S_FLUSH = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t state;

    // Window / kernel position counters: r outer, then c, i, j inner.
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] c_cnt;
    logic [3:0]        i_cnt;
    logic [3:0]        j_cnt;
    logic [ADDR_W-1:0] res_idx;

    // Capture tag pipeline: tag_q travels with pix_rd / flush strobe,
    // tag1 with mac_enable, tag2 in the cycle the MAC result is valid.
    logic tag_q;
    logic tag1;
    logic tag2;
    logic flush_q;

    // Result FIFO
    logic [RES_W-1:0]  fifo_data [4];
    logic [ADDR_W-1:0] fifo_addr [4];
    logic [1:0]        wr_ptr;
    logic [1:0]        rd_ptr;
    logic [2:0]        count;

    logic              push;
    logic              pop;
    logic [2:0]        occ_after_pop;
    logic              stall;

    logic              j_last;
    logic              i_last;
    logic              c_last;
    logic              r_last;
    logic              last_product;
    logic              tag_c;
    logic [ADDR_W-1:0] pix_addr_c;
    logic [5:0]        krn_addr_c;

    assign mac_ht    = 9'(K);
    assign mac_wt    = 9'(K);
    assign dbg_state = state;

    assign push      = tag2;
    assign pop       = (count != 3'd0) && res_ready;
    assign res_valid = (count != 3'd0);
    assign res_data  = fifo_data[rd_ptr];
    assign res_addr  = fifo_addr[rd_ptr];

    // Issue is held off while an entry would still sit in the FIFO after
    // this cycle's pop. At most three tagged enables are in flight behind
    // that decision, so the FIFO cannot overflow, and with res_ready high
    // the single waiting result always leaves in time (no bubbles).
    assign occ_after_pop = count - {2'b00, pop};
    assign stall         = (occ_after_pop != 3'd0);

    assign j_last       = (j_cnt == 4'(K - 1));
    assign i_last       = (i_cnt == 4'(K - 1));
    assign c_last       = (c_cnt == ADDR_W'(OW - 1));
    assign r_last       = (r_cnt == ADDR_W'(OH - 1));
    assign last_product = r_last && c_last && i_last && j_last;

    // The first product of a new window makes the MAC dump the previous
    // window, so it carries the capture tag; window 0 has nothing to dump.
    assign tag_c = (i_cnt == 4'd0) && (j_cnt == 4'd0) &&
                   !((r_cnt == '0) && (c_cnt == '0));

    assign pix_addr_c = ADDR_W'((int'(r_cnt) + int'(i_cnt)) * IMG_W +
                                int'(c_cnt) + int'(j_cnt));
    assign krn_addr_c = 6'(int'(i_cnt) * K + int'(j_cnt));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            pix_rd     <= 1'b0;
            pix_addr   <= '0;
            krn_addr   <= '0;
            mac_enable <= 1'b0;
            mac_clear  <= 1'b0;
            seq_err    <= 1'b0;
            r_cnt      <= '0;
            c_cnt      <= '0;
            i_cnt      <= '0;
            j_cnt      <= '0;
            res_idx    <= '0;
            tag_q      <= 1'b0;
            tag1       <= 1'b0;
            tag2       <= 1'b0;
            flush_q    <= 1'b0;
        end else begin
            done       <= 1'b0;
            mac_clear  <= 1'b0;
            pix_rd     <= 1'b0;
            flush_q    <= 1'b0;
            tag_q      <= 1'b0;
            mac_enable <= pix_rd | flush_q;
            tag1       <= tag_q;
            tag2       <= tag1;

            if (tag2) begin
                res_idx <= res_idx + 1'b1;
                if (!mac_done) begin
                    seq_err <= 1'b1;
                end
            end

            // busy stays high through the done cycle itself.
            if (done) begin
                busy <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (start && !busy) begin
                        state     <= S_CLR;
                        busy      <= 1'b1;
                        mac_clear <= 1'b1;
                    end
                end
                S_CLR: begin
                    r_cnt   <= '0;
                    c_cnt   <= '0;
                    i_cnt   <= '0;
                    j_cnt   <= '0;
                    res_idx <= '0;
                    state   <= S_RUN;
                end
                S_RUN: begin
                    if (!stall) begin
                        pix_rd   <= 1'b1;
                        pix_addr <= pix_addr_c;
                        krn_addr <= krn_addr_c;
                        tag_q    <= tag_c;
                        if (j_last) begin
                            j_cnt <= '0;
                            if (i_last) begin
                                i_cnt <= '0;
                                if (c_last) begin
                                    c_cnt <= '0;
                                    r_cnt <= r_cnt + 1'b1;
                                end else begin
                                    c_cnt <= c_cnt + 1'b1;
                                end
                            end else begin
                                i_cnt <= i_cnt + 1'b1;
                            end
                        end else begin
                            j_cnt <= j_cnt + 1'b1;
                        end
                        if (last_product) begin
                            state <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    // Extra enable without a read: makes the MAC dump the
                    // final window.
                    if (!stall) begin
                        flush_q <= 1'b1;
                        tag_q   <= 1'b1;
                        state   <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Wait for tagged enables still in flight as well as
                    // for the FIFO to empty.
                    if ((count == 3'd0) && !tag_q && !tag1 && !tag2) begin
                        mac_clear <= 1'b1;
                        done      <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int k = 0; k < 4; k++) begin
                fifo_data[k] <= '0;
                fifo_addr[k] <= '0;
            end
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= mac_out;
                fifo_addr[wr_ptr] <= res_idx;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_window_scheduler.sv
// tb_conv_window_scheduler
//   Directed bench for conv_window_scheduler. Two instances on a 4x4 map:
//   dut2 with K=2 and dut1 with K=1. Each has a behavioural pixel/weight
//   RAM (one-cycle read) and a MAC that dumps its accumulated window on
//   the enable following K*K products. Inputs change 1 ns after the rising
//   edge; outputs are observed on the falling edge.
module tb_conv_window_scheduler;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    // ---------------- dut2 (K=2) ----------------
    logic        start2, busy2, done2, pix_rd2, mac_enable2, mac_clear2;
    logic [9:0]  pix_addr2, res_addr2;
    logic [5:0]  krn_addr2;
    logic [8:0]  mac_ht2, mac_wt2;
    logic [20:0] mac_out2 = '0;
    logic        mac_done2 = 1'b0;
    logic        res_valid2, res_ready2, seq_err2;
    logic [20:0] res_data2;
    logic [2:0]  dbg_state2;

    // ---------------- dut1 (K=1) ----------------
    logic        start1, busy1, done1, pix_rd1, mac_enable1, mac_clear1;
    logic [9:0]  pix_addr1, res_addr1;
    logic [5:0]  krn_addr1;
    logic [8:0]  mac_ht1, mac_wt1;
    logic [20:0] mac_out1 = '0;
    logic        mac_done1 = 1'b0;
    logic        res_valid1, res_ready1, seq_err1;
    logic [20:0] res_data1;
    logic [2:0]  dbg_state1;

    conv_window_scheduler #(.IMG_W(4), .IMG_H(4), .K(2), .ADDR_W(10), .RES_W(21)) dut2 (
        .clk(clk), .reset_n(reset_n), .start(start2), .busy(busy2), .done(done2),
        .pix_rd(pix_rd2), .pix_addr(pix_addr2), .krn_addr(krn_addr2),
        .mac_enable(mac_enable2), .mac_clear(mac_clear2), .mac_ht(mac_ht2), .mac_wt(mac_wt2),
        .mac_out(mac_out2), .mac_done(mac_done2), .res_valid(res_valid2),
        .res_data(res_data2), .res_addr(res_addr2), .res_ready(res_ready2),
        .seq_err(seq_err2), .dbg_state(dbg_state2)
    );

    conv_window_scheduler #(.IMG_W(4), .IMG_H(4), .K(1), .ADDR_W(10), .RES_W(21)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .busy(busy1), .done(done1),
        .pix_rd(pix_rd1), .pix_addr(pix_addr1), .krn_addr(krn_addr1),
        .mac_enable(mac_enable1), .mac_clear(mac_clear1), .mac_ht(mac_ht1), .mac_wt(mac_wt1),
        .mac_out(mac_out1), .mac_done(mac_done1), .res_valid(res_valid1),
        .res_data(res_data1), .res_addr(res_addr1), .res_ready(res_ready1),
        .seq_err(seq_err1), .dbg_state(dbg_state1)
    );

    // ---------------- RAM and MAC models ----------------
    int pix_mem [16];
    int w2 [4];
    int pq2 = 0, kq2 = 0, acc2 = 0, cnt2 = 0;
    int pq1 = 0, acc1 = 0, cnt1 = 0;

    function automatic logic [20:0] sat21(input int v);
        if (v > 1048575)       return 21'h0FFFFF;
        else if (v < -1048576) return 21'h100000;
        else                   return 21'(v);
    endfunction

    always @(posedge clk) begin
        if (pix_rd2) begin
            pq2 <= pix_mem[pix_addr2[3:0]];
            kq2 <= w2[krn_addr2[1:0]];
        end
        if (mac_clear2) begin
            acc2 <= 0; cnt2 <= 0; mac_done2 <= 1'b0;
        end else if (mac_enable2) begin
            if (cnt2 == 4) begin
                mac_out2 <= sat21(acc2); mac_done2 <= 1'b1;
                acc2 <= pq2 * kq2; cnt2 <= 1;
            end else begin
                acc2 <= acc2 + pq2 * kq2; cnt2 <= cnt2 + 1;
            end
        end
    end

    // K=1 weight RAM holds the single weight 1.
    always @(posedge clk) begin
        if (pix_rd1) begin
            pq1 <= pix_mem[pix_addr1[3:0]];
        end
        if (mac_clear1) begin
            acc1 <= 0; cnt1 <= 0; mac_done1 <= 1'b0;
        end else if (mac_enable1) begin
            if (cnt1 == 1) begin
                mac_out1 <= sat21(acc1); mac_done1 <= 1'b1;
                acc1 <= pq1; cnt1 <= 1;
            end else begin
                acc1 <= acc1 + pq1; cnt1 <= cnt1 + 1;
            end
        end
    end

    // ---------------- output monitors ----------------
    logic [20:0] got_d2 [$];
    logic [9:0]  got_a2 [$];
    logic [20:0] got_d1 [$];
    logic [9:0]  got_a1 [$];
    int done_cnt2 = 0, rd_cnt2 = 0, busy_cnt2 = 0, done_cnt1 = 0;

    always @(negedge clk) begin
        if (res_valid2 && res_ready2) begin
            got_d2.push_back(res_data2);
            got_a2.push_back(res_addr2);
        end
        if (res_valid1 && res_ready1) begin
            got_d1.push_back(res_data1);
            got_a1.push_back(res_addr1);
        end
        if (done2)   done_cnt2++;
        if (pix_rd2) rd_cnt2++;
        if (busy2)   busy_cnt2++;
        if (done1)   done_cnt1++;
    end

    // ---------------- checking helpers ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start2();
        start2 = 1'b1;
        tick(1);
        start2 = 1'b0;
    endtask

    task automatic wait_done2(input string tag, input int budget);
        int base;
        int k;
        base = done_cnt2;
        k = 0;
        while (done_cnt2 == base && k < budget) begin
            tick(1);
            k++;
        end
        tick(3);
        chk({tag, "_done_once"}, done_cnt2 - base, 1);
    endtask

    // Checks that exactly 9 results arrived after index base, all equal to
    // val, with output indices 0..8 in order.
    task automatic chk_results2(input string tag, input int base, input logic [20:0] val);
        chk({tag, "_count"}, got_d2.size() - base, 9);
        for (int k = 0; k < 9; k++) begin
            chk({tag, "_data"}, {11'd0, got_d2[base + k]}, {11'd0, val});
            chk({tag, "_addr"}, {22'd0, got_a2[base + k]}, k);
        end
    endtask

    localparam logic [20:0] M5 = 21'h1FFFFB;  // -5 in 21 bits

    int b_res, b_rd, b_busy, b_done;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        start2 = 1'b0; start1 = 1'b0;
        res_ready2 = 1'b0; res_ready1 = 1'b0;
        for (int k = 0; k < 16; k++) pix_mem[k] = 1;
        for (int k = 0; k < 4; k++) w2[k] = 1;
        tick(3);

        // Reset state
        chk("rst_ctrl", {busy2, done2, pix_rd2, mac_enable2, mac_clear2, res_valid2, seq_err2}, 0);
        chk("rst_addr", {pix_addr2, krn_addr2}, 0);
        chk("rst_res", {res_data2, res_addr2}, 0);
        chk("rst_state", dbg_state2, 0);
        chk("rst_ht_wt", {mac_ht2, mac_wt2}, {9'd2, 9'd2});
        chk("rst_ht1", mac_ht1, 1);
        reset_n = 1'b1;
        tick(2);

        // Test 1: all ones, ready high -> nine results of 4, K*K cycles/window
        res_ready2 = 1'b1;
        b_res = got_d2.size(); b_busy = busy_cnt2;
        pulse_start2();
        wait_done2("t1", 200);
        chk_results2("t1", b_res, 21'd4);
        chk("t1_seq_err", seq_err2, 0);
        chk("t1_busy_cycles", busy_cnt2 - b_busy, 44);
        chk("t1_idle_after", {busy2, dbg_state2}, 0);

        // Test 2: p = x + 4y, weights {1,0,0,-1} -> every result -5
        for (int k = 0; k < 16; k++) pix_mem[k] = k;
        w2[0] = 1; w2[1] = 0; w2[2] = 0; w2[3] = -1;
        b_res = got_d2.size();
        pulse_start2();
        wait_done2("t2", 200);
        chk_results2("t2", b_res, M5);
        chk("t2_seq_err", seq_err2, 0);

        // Test 3: consumer stalled for 50 cycles
        res_ready2 = 1'b0;
        b_res = got_d2.size(); b_rd = rd_cnt2;
        pulse_start2();
        tick(50);
        chk("t3_rd_stalled", rd_cnt2 - b_rd, 8);
        chk("t3_pix_rd_low", pix_rd2, 0);
        chk("t3_none_popped", got_d2.size() - b_res, 0);
        chk("t3_head", {res_valid2, res_data2, res_addr2}, {1'b1, M5, 10'd0});
        chk("t3_busy", busy2, 1);
        res_ready2 = 1'b1;
        wait_done2("t3", 200);
        chk_results2("t3", b_res, M5);
        chk("t3_seq_err", seq_err2, 0);

        // Test 4: reset in the middle of a pass, then a clean pass
        pulse_start2();
        tick(19);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t4_rst_ctrl", {busy2, done2, pix_rd2, mac_enable2, mac_clear2, res_valid2, seq_err2}, 0);
        chk("t4_rst_addr", {pix_addr2, krn_addr2, res_addr2}, 0);
        chk("t4_rst_state", dbg_state2, 0);
        tick(2);
        reset_n = 1'b1;
        tick(2);
        b_res = got_d2.size();
        pulse_start2();
        wait_done2("t4", 200);
        chk_results2("t4", b_res, M5);
        chk("t4_seq_err", seq_err2, 0);

        // Test 5: start pulses while busy are ignored
        b_res = got_d2.size(); b_rd = rd_cnt2; b_done = done_cnt2;
        pulse_start2();
        tick(5);
        pulse_start2();
        tick(25);
        pulse_start2();
        wait_done2("t5", 200);
        tick(10);
        chk("t5_one_done", done_cnt2 - b_done, 1);
        chk("t5_reads", rd_cnt2 - b_rd, 36);
        chk_results2("t5", b_res, M5);

        // Test 6: K=1, ready toggling every cycle -> results equal pixels
        b_res = got_d1.size(); b_done = done_cnt1;
        start1 = 1'b1;
        tick(1);
        start1 = 1'b0;
        for (int k = 0; k < 400 && done_cnt1 == b_done; k++) begin
            res_ready1 = ~res_ready1;
            tick(1);
        end
        res_ready1 = 1'b1;
        tick(5);
        chk("t6_done_once", done_cnt1 - b_done, 1);
        chk("t6_count", got_d1.size() - b_res, 16);
        for (int k = 0; k < 16; k++) begin
            chk("t6_data", {11'd0, got_d1[b_res + k]}, k);
            chk("t6_addr", {22'd0, got_a1[b_res + k]}, k);
        end
        chk("t6_seq_err", seq_err1, 0);
        chk("t6_idle_after", {busy1, res_valid1}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
